nes_pad_scanner: RTL and testbench
==================================

# nes_pad_scanner

Scans one NES gamepad over its three-wire serial interface (latch, pulse, data) at a fixed poll rate and presents the eight button states as a stable, active-high parallel byte. Its `buttons` output drives the 8-bit `in_port` of the controller-input PIO, which the Nios II reads over Avalon. One instance is used per controller port.

## Interface
Parameters:
- `HALF_CYCLES`, default 300: clocks per half bit-period; 300 gives 6 µs at 50 MHz. Must be ≥ 4.
- `POLL_CYCLES`, default 833333: clocks between scan starts; 833333 gives about 60 Hz at 50 MHz. Must be > 17·HALF_CYCLES + 4.

Ports:
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `nes_data` in 1: serial data from the pad. Asynchronous to `clk`. Low means pressed.
- `nes_latch` out 1: parallel-load strobe to the pad, active-high.
- `nes_pulse` out 1: shift clock to the pad, active-high.
- `buttons` out 8: active-high button states. Bit 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- `scan_valid` out 1: one-cycle pulse when a scan result has been evaluated.

## Operation
- Free-running poll counter counts 0..POLL_CYCLES-1 and wraps. The wrap raises a start request.
- A start request is taken only in IDLE. A request that arrives while a scan is in progress is dropped.
- `nes_data` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- State machine:
  - IDLE: latch=0, pulse=0. On a start request, go to LATCH.
  - LATCH: latch=1 for 2·H cycles, then go to GAP.
  - GAP: latch=0 for H cycles. On the last cycle, sample bit 0, then go to PHI with k=1.
  - PHI: pulse=1 for H cycles, then go to PLO.
  - PLO: pulse=0 for H cycles. On the last cycle, sample bit k. If k<7, increment k and go to PHI. If k=7, go to DONE.
  - DONE: one cycle. Evaluate the result, assert `scan_valid`, then go to IDLE.
- Each sampled bit is stored inverted into a shift register, so pressed reads as 1.
- `buttons` changes only in DONE and updates all 8 bits at once. There are no partial updates.
- Each scan produces exactly 7 rising edges on `nes_pulse`.
- Reset mid-scan: the asynchronous reset forces all outputs to their reset values immediately. The state machine returns to IDLE, and the bit counter, half-period counter and poll counter clear to 0.

## Timing
- Reset values: `nes_latch`=0, `nes_pulse`=0, `buttons`=8'h00, `scan_valid`=0. The synchronizer flops reset to 1 (released).
- First `nes_latch` rise occurs POLL_CYCLES clocks after reset deasserts. Later latch rises occur every POLL_CYCLES clocks.
- Latch high lasts 2·H cycles. Each pulse is high H cycles and low H cycles.
- Scan length from latch rise to the last sample is 17·H cycles. DONE follows on the next cycle.
- `buttons` and `scan_valid` become visible on the cycle after DONE, i.e. 17·H+1 cycles after latch rise. Here `buttons` is registered and `scan_valid` is a registered pulse.
- Each sample sees the pad data as it was 2 cycles earlier, because of the synchronizer. H ≥ 4 keeps this well inside the stable window.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `NES_PAD_SCANNER_DEBOUNCE_EN` defined:
  - A 1-scan history register (reset 8'h00) holds the previous raw scan.
  - In DONE, `buttons` is loaded only if the current raw byte equals the history. Otherwise `buttons` holds its value.
  - The history register is always loaded with the current raw byte.
  - `scan_valid` still pulses every scan.
- Macro undefined: `buttons` is loaded with the raw byte in every DONE.

## Structure
- Package `nes_pad_pkg` holds:
  - the state enum (IDLE, LATCH, GAP, PHI, PLO, DONE);
  - the button bit-index constants (BTN_A=0 … BTN_RIGHT=7);
  - the width of the bit counter.
- One sub-module, `nes_data_sync`: a 2-flop synchronizer with a reset value parameter, instantiated for `nes_data`.
- Everything else stays in the top module: poll counter, half-period counter, bit counter, shift register, FSM.

## Test plan
Bench uses H=4, POLL=100 and a 4021-style pad model: parallel load while latch is high, shift on each pulse rising edge, data is the active-low current bit.
- Reset pulse, then release → all outputs 0; first latch rise 100 cycles after release; latch high exactly 8 cycles; 7 pulses, each 4 cycles high and 4 low.
- A+Start pressed → `buttons`=8'h09 and `scan_valid` high for 1 cycle, 69 cycles after latch rise.
- All released → 8'h00. Next scan with all pressed → 8'hFF. Up+Left pressed → 8'h50.
- Reset asserted during the 3rd PHI → latch and pulse drop to 0 in the same cycle, `buttons`=0; next latch rise 100 cycles after release.
- Debounce, with pad patterns 0x01, 0x01, 0x02, 0x04, 0x04:
  - macro defined → `buttons` reads 00, 01, 01, 01, 04 after each scan;
  - macro undefined → `buttons` follows the raw byte every scan.
- Pad model stuck low (data=0) for the full scan → 8'hFF, and exactly one `scan_valid` per 100 cycles.

Source files
------------

// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES gamepad scanner.
package nes_pad_pkg;

   // Scan sequencer states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      GAP   = 3'd2,
      PHI   = 3'd3,
      PLO   = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Bit positions of each button in the parallel byte
   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

   localparam int unsigned NUM_BUTTONS = 8;

   // Bit counter covers button indices 0..7
   localparam int unsigned BIT_CNT_W = 3;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(NUM_BUTTONS - 1);

endpackage

// File: rtl/nes_data_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
module nes_data_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; both come out of reset at the idle level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/nes_pad_scanner.sv
// NES gamepad scanner: periodically latches and shifts the pad's 4021
// register and presents the eight buttons as an active-high byte.
// Optional feature: define NES_PAD_SCANNER_DEBOUNCE_EN to update the
// button byte only when two consecutive scans agree.
module nes_pad_scanner
   import nes_pad_pkg::*;
#(
   parameter int unsigned HALF_CYCLES = 300,
   parameter int unsigned POLL_CYCLES = 833333
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       nes_data,
   output logic       nes_latch,
   output logic       nes_pulse,
   output logic [7:0] buttons,
   output logic       scan_valid
);

   localparam int unsigned POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam int unsigned HCNT_W = $clog2(2 * HALF_CYCLES);

   localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
   localparam logic [HCNT_W-1:0] LATCH_LAST = HCNT_W'(2 * HALF_CYCLES - 1);
   localparam logic [HCNT_W-1:0] HALF_LAST  = HCNT_W'(HALF_CYCLES - 1);

   logic [POLL_W-1:0]    poll_cnt;
   logic [HCNT_W-1:0]    hcnt;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [7:0]           raw_q;
   logic                 data_s;

   state_t state_q;
   state_t state_d;

   logic start_req;
   logic half_done;
   logic latch_d;
   logic pulse_d;
   logic sample_en;
   logic done;

   // Pad data crosses into the clk domain; idle line level is high
   nes_data_sync #(
      .RESET_VAL (1'b1)
   ) u_data_sync (
      .clk   (clk),
      .reset (reset),
      .d     (nes_data),
      .q     (data_s)
   );

   assign start_req = (poll_cnt == POLL_LAST);
   assign half_done = (hcnt == HALF_LAST);

   // Free-running poll timer; its wrap requests a new scan
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         poll_cnt <= '0;
      end else if (poll_cnt == POLL_LAST) begin
         poll_cnt <= '0;
      end else begin
         poll_cnt <= poll_cnt + POLL_W'(1);
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; requests seen outside IDLE are simply ignored
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_req)           state_d = LATCH;
         LATCH:   if (hcnt == LATCH_LAST)  state_d = GAP;
         GAP:     if (half_done)           state_d = PHI;
         PHI:     if (half_done)           state_d = PLO;
         PLO:     if (half_done)           state_d = (bit_cnt == LAST_BIT) ? DONE : PHI;
         DONE:                             state_d = IDLE;
         default:                          state_d = IDLE;
      endcase
   end

   // Output decode; strobes are decoded from the next state so the
   // registered pins line up with the state they belong to
   always_comb begin
      latch_d   = 1'b0;
      pulse_d   = 1'b0;
      sample_en = 1'b0;
      done      = 1'b0;
      latch_d   = (state_d == LATCH);
      pulse_d   = (state_d == PHI);
      sample_en = half_done && ((state_q == GAP) || (state_q == PLO));
      done      = (state_q == DONE);
   end

   // Half-period timer restarts on every state change
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcnt <= '0;
      end else if ((state_d != state_q) || (state_q == IDLE)) begin
         hcnt <= '0;
      end else begin
         hcnt <= hcnt + HCNT_W'(1);
      end
   end

   // Index of the next button to be sampled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt <= '0;
      end else if (sample_en) begin
         if (state_q == GAP) begin
            bit_cnt <= BIT_CNT_W'(1);
         end else if (bit_cnt != LAST_BIT) begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
         end
      end else if (done) begin
         bit_cnt <= '0;
      end
   end

   // Shift in inverted samples LSB-first so button 0 lands in bit 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         raw_q <= '0;
      end else if (sample_en) begin
         raw_q <= {~data_s, raw_q[7:1]};
      end
   end

`ifdef NES_PAD_SCANNER_DEBOUNCE_EN
   logic [7:0] hist_q;

   // Previous raw scan, compared against the current one in DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= '0;
      end else if (done) begin
         hist_q <= raw_q;
      end
   end
`endif

   // Registered pad strobes and scan result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nes_latch  <= 1'b0;
         nes_pulse  <= 1'b0;
         scan_valid <= 1'b0;
         buttons    <= '0;
      end else begin
         nes_latch  <= latch_d;
         nes_pulse  <= pulse_d;
         scan_valid <= done;
         if (done) begin
`ifdef NES_PAD_SCANNER_DEBOUNCE_EN
            if (raw_q == hist_q) begin
               buttons <= raw_q;
            end
`else
            buttons <= raw_q;
`endif
         end
      end
   end

endmodule

// File: tb/tb_nes_pad_scanner.sv
// Self-checking bench for nes_pad_scanner with a 4021-style pad model.
// Honours NES_PAD_SCANNER_DEBOUNCE_EN in its reference model.
module tb_nes_pad_scanner;

   localparam int unsigned H     = 4;
   localparam int unsigned POLL  = 100;
   localparam int          SV_AT = 17 * H + 1;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       nes_data;
   logic       nes_latch;
   logic       nes_pulse;
   logic       scan_valid;
   logic [7:0] buttons;

   int pass_cnt  = 0;
   int check_cnt = 0;
   int cyc       = 0;
   int last_rise = 0;

   // Pad model state: pad_pattern is active-high "pressed"
   logic [7:0] pad_pattern = 8'h00;
   logic [7:0] pad_sr      = 8'hFF;
   logic       stuck       = 1'b0;

   // Reference model state
   logic [7:0] ref_btn  = 8'h00;
   logic [7:0] ref_hist = 8'h00;

   nes_pad_scanner #(
      .HALF_CYCLES (H),
      .POLL_CYCLES (POLL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .nes_data   (nes_data),
      .nes_latch  (nes_latch),
      .nes_pulse  (nes_pulse),
      .buttons    (buttons),
      .scan_valid (scan_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // 4021: parallel load while latch high, shift on pulse rising edge
   always @(posedge nes_latch or posedge nes_pulse) begin
      if (nes_latch) pad_sr <= ~pad_pattern;
      else           pad_sr <= {1'b1, pad_sr[7:1]};
   end

   assign nes_data = stuck ? 1'b0 : pad_sr[0];

   // Expected button byte after a scan that read 'raw'
   task automatic ref_scan(input logic [7:0] raw);
`ifdef NES_PAD_SCANNER_DEBOUNCE_EN
      if (raw == ref_hist) ref_btn = raw;
      ref_hist = raw;
`else
      ref_btn = raw;
`endif
   endtask

   task automatic ref_reset();
      ref_btn  = 8'h00;
      ref_hist = 8'h00;
   endtask

   // Waits for a latch rise, then observes 100 cycles of the scan.
   // t = 0 is the first negedge after the latch-rise clock edge.
   task automatic run_scan(output int rise_cyc, output logic [7:0] b_pre,
                           output logic [7:0] b_post, output int sv_cnt,
                           output int sv_pos, output int lat_err,
                           output int pul_err, output int rises);
      int   n;
      logic prev_p;
      logic exp_l;
      logic exp_p;
      n = 0; rise_cyc = -1; sv_cnt = 0; sv_pos = -1;
      lat_err = 0; pul_err = 0; rises = 0;
      b_pre = buttons; b_post = buttons;
      while (nes_latch !== 1'b1 && n < 400) begin
         @(posedge clk); @(negedge clk); n++;
      end
      if (nes_latch !== 1'b1) begin
         lat_err = 999; pul_err = 999;
         return;
      end
      rise_cyc = cyc;
      prev_p   = 1'b0;
      for (int t = 0; t < 100; t++) begin
         if (t > 0) begin @(posedge clk); @(negedge clk); end
         exp_l = (t < 2 * H);
         exp_p = (t >= 3 * H) && (t < 17 * H) && (((t - 3 * H) % (2 * H)) < H);
         if (nes_latch !== exp_l) lat_err++;
         if (nes_pulse !== exp_p) pul_err++;
         if (nes_pulse === 1'b1 && prev_p === 1'b0) rises++;
         prev_p = nes_pulse;
         if (scan_valid === 1'b1) begin sv_cnt++; sv_pos = t; end
         if (t == SV_AT - 1) b_pre  = buttons;
         if (t == SV_AT)     b_post = buttons;
      end
   endtask

   task automatic test_reset();
      int rise, svc, svp, le, pe, rs, rel;
      logic [7:0] bpre, bpost;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_cnt++; if (nes_latch !== 1'b0) $display("FAIL reset_latch: got %b want 0", nes_latch); else pass_cnt++;
      check_cnt++; if (nes_pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", nes_pulse); else pass_cnt++;
      check_cnt++; if (buttons !== 8'h00) $display("FAIL reset_buttons: got %h want 00", buttons); else pass_cnt++;
      check_cnt++; if (scan_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", scan_valid); else pass_cnt++;
      pad_pattern = 8'h00;
      ref_reset();
      reset = 1'b0;
      rel = cyc;
      run_scan(rise, bpre, bpost, svc, svp, le, pe, rs);
      ref_scan(8'h00);
      last_rise = rise;
      check_cnt++; if (rise - rel !== POLL) $display("FAIL first_latch_delay: got %0d want %0d", rise - rel, POLL); else pass_cnt++;
      check_cnt++; if (le !== 0) $display("FAIL latch_shape: got %0d bad cycles want 0", le); else pass_cnt++;
      check_cnt++; if (pe !== 0) $display("FAIL pulse_shape: got %0d bad cycles want 0", pe); else pass_cnt++;
      check_cnt++; if (rs !== 7) $display("FAIL pulse_count: got %0d want 7", rs); else pass_cnt++;
      check_cnt++; if (bpost !== ref_btn) $display("FAIL first_buttons: got %h want %h", bpost, ref_btn); else pass_cnt++;
   endtask

   task automatic test_a_start();
      int rise, svc, svp, le, pe, rs;
      logic [7:0] bpre, bpost, exp_pre;
      pad_pattern = 8'h09;
      exp_pre = ref_btn;
      run_scan(rise, bpre, bpost, svc, svp, le, pe, rs);
      ref_scan(8'h09);
      check_cnt++; if (rise - last_rise !== POLL) $display("FAIL poll_period: got %0d want %0d", rise - last_rise, POLL); else pass_cnt++;
      last_rise = rise;
      check_cnt++; if (svp !== SV_AT) $display("FAIL valid_pos: got %0d want %0d", svp, SV_AT); else pass_cnt++;
      check_cnt++; if (svc !== 1) $display("FAIL valid_count: got %0d want 1", svc); else pass_cnt++;
      check_cnt++; if (bpre !== exp_pre) $display("FAIL a_start_pre: got %h want %h", bpre, exp_pre); else pass_cnt++;
      check_cnt++; if (bpost !== ref_btn) $display("FAIL a_start_buttons: got %h want %h", bpost, ref_btn); else pass_cnt++;
      check_cnt++; if (le + pe !== 0) $display("FAIL a_start_wave: got %0d bad cycles want 0", le + pe); else pass_cnt++;
   endtask

   task automatic test_patterns();
      int rise, svc, svp, le, pe, rs;
      logic [7:0] bpre, bpost, exp_pre;
      logic [7:0] pats [6];
      pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h50;
      pats[3] = 8'($urandom); pats[4] = 8'($urandom); pats[5] = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
         pad_pattern = pats[i];
         exp_pre = ref_btn;
         run_scan(rise, bpre, bpost, svc, svp, le, pe, rs);
         ref_scan(pats[i]);
         last_rise = rise;
         check_cnt++; if (bpost !== ref_btn) $display("FAIL pattern_%0d: got %h want %h (pad %h)", i, bpost, ref_btn, pats[i]); else pass_cnt++;
         check_cnt++; if (bpre !== exp_pre) $display("FAIL pattern_pre_%0d: got %h want %h", i, bpre, exp_pre); else pass_cnt++;
         check_cnt++; if (svc !== 1 || svp !== SV_AT) $display("FAIL pattern_valid_%0d: got count %0d pos %0d want 1 at %0d", i, svc, svp, SV_AT); else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_scan();
      int n, rel, rise, svc, svp, le, pe, rs;
      logic [7:0] bpre, bpost;
      pad_pattern = 8'hA5;
      n = 0;
      while (nes_latch !== 1'b1 && n < 400) begin @(posedge clk); @(negedge clk); n++; end
      check_cnt++; if (nes_latch !== 1'b1) $display("FAIL mid_latch_seen: got %b want 1", nes_latch); else pass_cnt++;
      // advance into the third pulse-high phase
      repeat (3 * H + 4 * H + 1) begin @(posedge clk); @(negedge clk); end
      check_cnt++; if (nes_pulse !== 1'b1) $display("FAIL mid_pulse_high: got %b want 1", nes_pulse); else pass_cnt++;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_cnt++; if (nes_pulse !== 1'b0) $display("FAIL mid_pulse_drop: got %b want 0", nes_pulse); else pass_cnt++;
      check_cnt++; if (nes_latch !== 1'b0) $display("FAIL mid_latch_low: got %b want 0", nes_latch); else pass_cnt++;
      check_cnt++; if (buttons !== 8'h00) $display("FAIL mid_buttons: got %h want 00", buttons); else pass_cnt++;
      ref_reset();
      @(negedge clk);
      reset = 1'b0;
      rel = cyc;
      pad_pattern = 8'h3C;
      run_scan(rise, bpre, bpost, svc, svp, le, pe, rs);
      ref_scan(8'h3C);
      last_rise = rise;
      check_cnt++; if (rise - rel !== POLL) $display("FAIL mid_relatch_delay: got %0d want %0d", rise - rel, POLL); else pass_cnt++;
      check_cnt++; if (rs !== 7) $display("FAIL mid_pulse_count: got %0d want 7", rs); else pass_cnt++;
      check_cnt++; if (bpost !== ref_btn) $display("FAIL mid_after_buttons: got %h want %h", bpost, ref_btn); else pass_cnt++;
   endtask

   task automatic test_debounce();
      int rise, svc, svp, le, pe, rs;
      logic [7:0] bpre, bpost;
      logic [7:0] pats [5];
      pats[0] = 8'h01; pats[1] = 8'h01; pats[2] = 8'h02; pats[3] = 8'h04; pats[4] = 8'h04;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ref_reset();
      for (int i = 0; i < 5; i++) begin
         pad_pattern = pats[i];
         run_scan(rise, bpre, bpost, svc, svp, le, pe, rs);
         ref_scan(pats[i]);
         last_rise = rise;
         check_cnt++; if (bpost !== ref_btn) $display("FAIL debounce_%0d: got %h want %h (pad %h)", i, bpost, ref_btn, pats[i]); else pass_cnt++;
         check_cnt++; if (svc !== 1) $display("FAIL debounce_valid_%0d: got %0d want 1", i, svc); else pass_cnt++;
      end
   endtask

   task automatic test_stuck_low();
      int rise, svc, svp, le, pe, rs;
      logic [7:0] bpre, bpost;
      stuck = 1'b1;
      for (int i = 0; i < 2; i++) begin
         run_scan(rise, bpre, bpost, svc, svp, le, pe, rs);
         ref_scan(8'hFF);
         check_cnt++; if (rise - last_rise !== POLL) $display("FAIL stuck_period_%0d: got %0d want %0d", i, rise - last_rise, POLL); else pass_cnt++;
         last_rise = rise;
         check_cnt++; if (bpost !== ref_btn) $display("FAIL stuck_buttons_%0d: got %h want %h", i, bpost, ref_btn); else pass_cnt++;
         check_cnt++; if (svc !== 1) $display("FAIL stuck_valid_%0d: got %0d want 1", i, svc); else pass_cnt++;
      end
      stuck = 1'b0;
   endtask

   initial begin
      test_reset();
      test_a_start();
      test_patterns();
      test_reset_mid_scan();
      test_debounce();
      test_stuck_low();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
